mesh_xy_router: RTL and testbench

Parametrised 5-port wormhole router for an arbitrary ROWS x COLS 2D mesh. It is the building block for generated meshes of any size, replacing fixed-size hand-wired meshes. Each input has its own FIFO. Routing is deterministic XY (dimension-ordered). Each output has a round-robin arbiter that stays locked to one packet from head to tail. Packets with an out-of-range destination are dropped and counted.

---
 rtl/mesh_xy_router.sv | 232 +++++++++++++++++++++++
 tb/tb_mesh_xy_router.sv | 366 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mesh_xy_router.sv
// mesh_xy_router: 5-port wormhole router for one node of a ROWS x COLS mesh.
//
// Each input port owns a FIFO. The flit at each FIFO front is routed
// dimension-ordered (X first, then Y). Each output has a round-robin arbiter
// that locks onto a packet from head to tail, followed by one idle cycle
// before re-arbitration. Heads whose destination lies outside the mesh are
// discarded together with the rest of their packet and counted in drop_count.
//
// Ports (port index: 0 = local, 1 = X+, 2 = X-, 3 = Y+, 4 = Y-):
//   clk, rst        clock, synchronous active-high reset
//   data_in_bus     5 input flits, slice i = port i
//   valid_in_bus    per-port input valid
//   ready_in_bus    per-port input ready (low while rst is high)
//   data_out_bus    5 output flits from the output registers
//   valid_out_bus   per-port output valid
//   ready_out_bus   per-port downstream ready
//   drop_count      saturating count of dropped packets
//
// Handshake: on every port a flit moves exactly on a rising edge where valid
// and ready are both high; a sender holds valid and data stable until then,
// and ready never depends on valid.
//
// Flit format: type = flit[DATA_WIDTH-1 -: TYPE_WIDTH]
// (0 single, 1 head, 2 body, 3 tail); destination = flit[DEST_WIDTH-1:0],
// encoded as dy*COLS + dx.
module mesh_xy_router #(
    parameter int ROWS       = 2,
    parameter int COLS       = 2,
    parameter int X          = 0,
    parameter int Y          = 0,
    parameter int DATA_WIDTH = 32,
    parameter int TYPE_WIDTH = 2,
    parameter int FIFO_DEPTH = 16,
    parameter int DEST_WIDTH = (ROWS * COLS > 1) ? $clog2(ROWS * COLS) : 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [5*DATA_WIDTH-1:0] data_in_bus,
    input  logic [4:0]              valid_in_bus,
    output logic [4:0]              ready_in_bus,
    output logic [5*DATA_WIDTH-1:0] data_out_bus,
    output logic [4:0]              valid_out_bus,
    input  logic [4:0]              ready_out_bus,
    output logic [7:0]              drop_count
);
    localparam int NP    = 5;
    localparam int AW    = $clog2(FIFO_DEPTH);
    localparam int NODES = ROWS * COLS;

    localparam logic [TYPE_WIDTH-1:0] T_SINGLE = TYPE_WIDTH'(0);
    localparam logic [TYPE_WIDTH-1:0] T_HEAD   = TYPE_WIDTH'(1);
    localparam logic [TYPE_WIDTH-1:0] T_TAIL   = TYPE_WIDTH'(3);
    localparam logic [AW:0]           PTR_ONE  = (AW+1)'(1);
    localparam logic [AW:0]           DEPTH_V  = (AW+1)'(FIFO_DEPTH);

    // Input FIFOs; pointers carry one extra bit so full and empty differ.
    logic [DATA_WIDTH-1:0] mem [NP][FIFO_DEPTH];
    logic [AW:0]           wr_ptr [NP];
    logic [AW:0]           rd_ptr [NP];
    logic [AW:0]           count  [NP];
    logic [NP-1:0]         wr_en;

    // Front-of-FIFO decode
    logic [DATA_WIDTH-1:0] front [NP];
    logic [TYPE_WIDTH-1:0] ftype [NP];
    logic [2:0]            route [NP];
    logic [NP-1:0]         nonempty, is_head, route_ok;

    // Per-input state: discarding the remainder of an out-of-range packet
    logic [NP-1:0]         dropping;

    // Per-output state
    logic [NP-1:0]         locked;
    logic [NP-1:0]         hold;      // idle cycle after a locked packet's tail
    logic [2:0]            owner  [NP];
    logic [2:0]            rr_ptr [NP];
    logic [DATA_WIDTH-1:0] out_data [NP];
    logic [NP-1:0]         out_valid;

    // Arbitration results
    logic [NP-1:0]         can_accept, gnt_valid, owner_any;
    logic [2:0]            gnt_idx [NP];
    logic [NP-1:0]         out_pop, discard, drop_head, pop;
    logic [3:0]            drops_now;
    logic [8:0]            drop_sum;

    always_comb begin
        for (int i = 0; i < NP; i++) begin
            count[i]        = wr_ptr[i] - rd_ptr[i];
            ready_in_bus[i] = !rst && (count[i] < DEPTH_V);
            wr_en[i]        = valid_in_bus[i] && ready_in_bus[i];
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < NP; i++) begin
            if (wr_en[i]) begin
                mem[i][wr_ptr[i][AW-1:0]] <= data_in_bus[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // XY route computation on each FIFO front
    always_comb begin
        int dest, dx, dy;
        dest = 0;
        dx   = 0;
        dy   = 0;
        for (int i = 0; i < NP; i++) begin
            front[i]    = mem[i][rd_ptr[i][AW-1:0]];
            ftype[i]    = front[i][DATA_WIDTH-1 -: TYPE_WIDTH];
            nonempty[i] = (wr_ptr[i] != rd_ptr[i]);
            is_head[i]  = (ftype[i] == T_SINGLE) || (ftype[i] == T_HEAD);
            dest        = int'(front[i][DEST_WIDTH-1:0]);
            dx          = dest % COLS;
            dy          = dest / COLS;
            route_ok[i] = (dest < NODES);
            if (dx > X)      route[i] = 3'd1;
            else if (dx < X) route[i] = 3'd2;
            else if (dy > Y) route[i] = 3'd3;
            else if (dy < Y) route[i] = 3'd4;
            else             route[i] = 3'd0;
        end
    end

    // Output arbitration and pop generation
    always_comb begin
        int   idx;
        logic found;
        idx       = 0;
        found     = 1'b0;
        owner_any = '0;
        gnt_valid = '0;
        out_pop   = '0;
        for (int o = 0; o < NP; o++) begin
            gnt_idx[o]    = 3'd0;
            can_accept[o] = !out_valid[o] || ready_out_bus[o];
            if (locked[o]) owner_any[owner[o]] = 1'b1;
        end
        for (int o = 0; o < NP; o++) begin
            found = 1'b0;
            if (can_accept[o]) begin
                if (locked[o]) begin
                    if (nonempty[owner[o]]) begin
                        gnt_valid[o] = 1'b1;
                        gnt_idx[o]   = owner[o];
                    end
                end else if (!hold[o]) begin
                    for (int k = 0; k < NP; k++) begin
                        idx = (int'(rr_ptr[o]) + k) % NP;
                        if (!found && nonempty[idx] && !dropping[idx] && !owner_any[idx] &&
                            is_head[idx] && route_ok[idx] && (route[idx] == 3'(o))) begin
                            found        = 1'b1;
                            gnt_valid[o] = 1'b1;
                            gnt_idx[o]   = 3'(idx);
                        end
                    end
                end
            end
            if (gnt_valid[o]) out_pop[gnt_idx[o]] = 1'b1;
        end
        drops_now = '0;
        for (int i = 0; i < NP; i++) begin
            // An unowned input discards: the rest of a dropped packet,
            // stray body/tail flits, and heads that leave the mesh.
            discard[i]   = nonempty[i] && !owner_any[i] &&
                           (dropping[i] || !is_head[i] || !route_ok[i]);
            drop_head[i] = nonempty[i] && !owner_any[i] && !dropping[i] &&
                           is_head[i] && !route_ok[i];
            pop[i]       = out_pop[i] || discard[i];
            drops_now    = drops_now + 4'(drop_head[i]);
        end
        drop_sum = {1'b0, drop_count} + 9'(drops_now);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NP; i++) begin
                wr_ptr[i]   <= '0;
                rd_ptr[i]   <= '0;
                owner[i]    <= '0;
                rr_ptr[i]   <= '0;
                out_data[i] <= '0;
            end
            dropping   <= '0;
            locked     <= '0;
            hold       <= '0;
            out_valid  <= '0;
            drop_count <= '0;
        end else begin
            for (int i = 0; i < NP; i++) begin
                if (wr_en[i]) wr_ptr[i] <= wr_ptr[i] + PTR_ONE;
                if (pop[i])   rd_ptr[i] <= rd_ptr[i] + PTR_ONE;
                if (drop_head[i] && (ftype[i] == T_HEAD)) begin
                    dropping[i] <= 1'b1;
                end else if (dropping[i] && pop[i] && (ftype[i] == T_TAIL)) begin
                    dropping[i] <= 1'b0;
                end
            end
            for (int o = 0; o < NP; o++) begin
                hold[o] <= 1'b0;
                if (gnt_valid[o]) begin
                    out_data[o]  <= front[gnt_idx[o]];
                    out_valid[o] <= 1'b1;
                    if (locked[o]) begin
                        if (ftype[gnt_idx[o]] == T_TAIL) begin
                            locked[o] <= 1'b0;
                            hold[o]   <= 1'b1;
                        end
                    end else begin
                        rr_ptr[o] <= (gnt_idx[o] == 3'd4) ? 3'd0 : gnt_idx[o] + 3'd1;
                        if (ftype[gnt_idx[o]] == T_HEAD) begin
                            locked[o] <= 1'b1;
                            owner[o]  <= gnt_idx[o];
                        end
                    end
                end else if (ready_out_bus[o]) begin
                    out_valid[o] <= 1'b0;
                end
            end
            drop_count <= drop_sum[8] ? 8'hFF : drop_sum[7:0];
        end
    end

    always_comb begin
        for (int o = 0; o < NP; o++) begin
            data_out_bus[o*DATA_WIDTH +: DATA_WIDTH] = out_data[o];
        end
    end
    assign valid_out_bus = out_valid;

endmodule

// File: tb/tb_mesh_xy_router.sv
// Bench for mesh_xy_router configured as node (1,1) of a 4x4 mesh with a
// 5-bit destination field so out-of-range destinations are expressible.
module tb_mesh_xy_router;
    localparam int DW    = 32;
    localparam int DESTW = 5;
    localparam int EW    = 3 + DW;   // {output port, flit}

    logic            clk = 1'b0;
    logic            rst;
    logic [5*DW-1:0] data_in_bus;
    logic [4:0]      valid_in_bus;
    logic [4:0]      ready_in_bus;
    logic [5*DW-1:0] data_out_bus;
    logic [4:0]      valid_out_bus;
    logic [4:0]      ready_out_bus;
    logic [7:0]      drop_count;

    mesh_xy_router #(
        .ROWS(4), .COLS(4), .X(1), .Y(1),
        .DATA_WIDTH(DW), .TYPE_WIDTH(2), .FIFO_DEPTH(16), .DEST_WIDTH(DESTW)
    ) dut (
        .clk(clk), .rst(rst),
        .data_in_bus(data_in_bus), .valid_in_bus(valid_in_bus), .ready_in_bus(ready_in_bus),
        .data_out_bus(data_out_bus), .valid_out_bus(valid_out_bus), .ready_out_bus(ready_out_bus),
        .drop_count(drop_count)
    );

    // Clock / cycle counter
    always #5 clk = ~clk;
    int cycle = 0;
    always @(posedge clk) cycle++;

    // Scoreboard
    int              checks   = 0;
    int              failures = 0;
    int              accepted = 0;
    logic [EW-1:0]   exp_q[$];
    int              cyc_q[$];

    always @(negedge clk) begin
        logic [EW-1:0] got, want;
        if (!rst) begin
            for (int p = 0; p < 5; p++) begin
                if (valid_out_bus[p] && ready_out_bus[p]) begin
                    got = {3'(p), data_out_bus[p*DW +: DW]};
                    cyc_q.push_back(cycle);
                    checks++;
                    if (exp_q.size() == 0) begin
                        failures++;
                        $display("FAIL out_unexpected port=%0d got=%h required=none", p, got[DW-1:0]);
                    end else begin
                        want = exp_q.pop_front();
                        if (got !== want) begin
                            failures++;
                            $display("FAIL out_flit got port=%0d data=%h required port=%0d data=%h",
                                     got[EW-1:DW], got[DW-1:0], want[EW-1:DW], want[DW-1:0]);
                        end
                    end
                end
            end
        end
    end

    function automatic logic [DW-1:0] mk(input logic [1:0] t, input int dest);
        logic [DW-1:0] f;
        f = {t, 30'($urandom)};
        f[DESTW-1:0] = DESTW'(dest);
        return f;
    endfunction

    function automatic logic [EW-1:0] ex(input int p, input logic [DW-1:0] f);
        return {3'(p), f};
    endfunction

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] req);
        checks++;
        if (got !== req) begin
            failures++;
            $display("FAIL %s got=%0h required=%0h", name, got, req);
        end
    endtask

    // Driver: holds valid until the handshake edge; leaves valid high so the
    // caller must follow with another send or idle.
    task automatic send(input int p, input logic [DW-1:0] f);
        bit acc;
        int n;
        data_in_bus[p*DW +: DW] = f;
        valid_in_bus[p] = 1'b1;
        acc = 1'b0;
        n = 0;
        while (!acc && n < 200) begin
            @(negedge clk);
            acc = ready_in_bus[p];
            @(posedge clk);
            #1;
            n++;
        end
        if (!acc) begin
            checks++;
            failures++;
            $display("FAIL send_timeout port=%0d got=no_ready required=ready", p);
        end else begin
            accepted++;
        end
    endtask

    task automatic idle(input int p);
        valid_in_bus[p] = 1'b0;
    endtask

    task automatic wait_drain(input string name);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 300) begin
            @(posedge clk);
            #1;
            n++;
        end
        repeat (4) @(posedge clk);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL %s_drain got=%0d_left required=0", name, exp_q.size());
            exp_q.delete();
        end
    endtask

    typedef struct {
        int in_port;
        int dest;
        int out_port;
        bit drop;
    } vec_t;

    initial begin
        #1_000_000;
        failures++;
        $display("FAIL watchdog got=timeout required=finish");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        vec_t          vecs[13];
        logic [DW-1:0] f, sf;
        logic [DW-1:0] a1[3], a2[3], pk[20];
        logic [1:0]    types3[3];
        int            hs, exp_drops, d;

        // XY routing expectations for node (1,1) in a 4x4 mesh
        vecs[0]  = '{0,  5, 0, 1'b0};
        vecs[1]  = '{0,  3, 1, 1'b0};
        vecs[2]  = '{1, 13, 3, 1'b0};
        vecs[3]  = '{2,  0, 2, 1'b0};
        vecs[4]  = '{3,  4, 2, 1'b0};
        vecs[5]  = '{4,  1, 4, 1'b0};
        vecs[6]  = '{0,  9, 3, 1'b0};
        vecs[7]  = '{2,  7, 1, 1'b0};
        vecs[8]  = '{1, 20, 0, 1'b1};
        vecs[9]  = '{3, 16, 0, 1'b1};
        vecs[10] = '{0,  6, 1, 1'b0};
        vecs[11] = '{4, 12, 2, 1'b0};
        vecs[12] = '{3, 15, 1, 1'b0};
        types3[0] = 2'b01;
        types3[1] = 2'b10;
        types3[2] = 2'b11;
        exp_drops = 0;

        // Reset
        rst = 1'b1;
        valid_in_bus = '0;
        data_in_bus = '0;
        ready_out_bus = '1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_valid_out", 64'(valid_out_bus), 64'h0);
        chk("rst_ready_in", 64'(ready_in_bus), 64'h0);
        chk("rst_data_out", 64'(|data_out_bus), 64'h0);
        chk("rst_drop_count", 64'(drop_count), 64'h0);
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("ready_after_rst", 64'(ready_in_bus), 64'h1f);

        // Latency: handshake in cycle t, valid_out visible in cycle t+2
        cyc_q.delete();
        f = mk(2'b00, 5);
        exp_q.push_back(ex(0, f));
        send(0, f);
        hs = cycle - 1;
        idle(0);
        wait_drain("latency");
        chk("latency", 64'((cyc_q.size() > 0) ? cyc_q[0] - hs : -1), 64'd2);

        // Two 3-flit packets to the local port in the same cycle
        cyc_q.delete();
        for (int k = 0; k < 3; k++) begin
            a1[k] = mk(types3[k], 5);
            a2[k] = mk(types3[k], 5);
        end
        for (int k = 0; k < 3; k++) exp_q.push_back(ex(0, a1[k]));
        for (int k = 0; k < 3; k++) exp_q.push_back(ex(0, a2[k]));
        for (int k = 0; k < 3; k++) begin
            data_in_bus[1*DW +: DW] = a1[k];
            data_in_bus[2*DW +: DW] = a2[k];
            valid_in_bus[1] = 1'b1;
            valid_in_bus[2] = 1'b1;
            @(posedge clk);
            #1;
        end
        idle(1);
        idle(2);
        wait_drain("arb");
        chk("arb_count", 64'(cyc_q.size()), 64'd6);
        if (cyc_q.size() == 6) begin
            chk("arb_burst_a", 64'(cyc_q[2] - cyc_q[0]), 64'd2);
            chk("arb_bubble", 64'(cyc_q[3] - cyc_q[2]), 64'd2);
            chk("arb_burst_b", 64'(cyc_q[5] - cyc_q[3]), 64'd2);
        end

        // Pointer now 3: input 3 beats input 2
        a1[0] = mk(2'b00, 5);
        a2[0] = mk(2'b00, 5);
        exp_q.push_back(ex(0, a2[0]));
        exp_q.push_back(ex(0, a1[0]));
        data_in_bus[2*DW +: DW] = a1[0];
        data_in_bus[3*DW +: DW] = a2[0];
        valid_in_bus[2] = 1'b1;
        valid_in_bus[3] = 1'b1;
        @(posedge clk);
        #1;
        idle(2);
        idle(3);
        wait_drain("rr_ptr");

        // Routing table of single flits
        for (int v = 0; v < 13; v++) begin
            f = mk(2'b00, vecs[v].dest);
            if (vecs[v].drop) exp_drops++;
            else exp_q.push_back(ex(vecs[v].out_port, f));
            send(vecs[v].in_port, f);
            idle(vecs[v].in_port);
            wait_drain("route_vec");
            chk("route_vec_drops", 64'(drop_count), 64'(exp_drops));
        end

        // Wormhole packets, back-to-back on the output
        cyc_q.delete();
        for (int k = 0; k < 4; k++) begin
            pk[k] = mk((k == 0) ? 2'b01 : (k == 3) ? 2'b11 : 2'b10, 3);
            exp_q.push_back(ex(1, pk[k]));
        end
        for (int k = 0; k < 4; k++) send(0, pk[k]);
        idle(0);
        wait_drain("worm_x");
        chk("worm_x_span", 64'((cyc_q.size() == 4) ? cyc_q[3] - cyc_q[0] : -1), 64'd3);
        for (int k = 0; k < 4; k++) begin
            pk[k] = mk((k == 0) ? 2'b01 : (k == 3) ? 2'b11 : 2'b10, 13);
            exp_q.push_back(ex(3, pk[k]));
        end
        for (int k = 0; k < 4; k++) send(0, pk[k]);
        idle(0);
        wait_drain("worm_y");

        // Stray body flit is discarded silently
        f = mk(2'b10, 5);
        sf = mk(2'b00, 5);
        exp_q.push_back(ex(0, sf));
        send(2, f);
        send(2, sf);
        idle(2);
        wait_drain("stray");
        chk("stray_drops", 64'(drop_count), 64'(exp_drops));

        // Backpressure: output 1 stalled for 40 cycles
        ready_out_bus[1] = 1'b0;
        for (int k = 0; k < 20; k++) begin
            pk[k] = mk((k == 0) ? 2'b01 : (k == 19) ? 2'b11 : 2'b10, 3);
            exp_q.push_back(ex(1, pk[k]));
        end
        accepted = 0;
        fork
            begin
                for (int k = 0; k < 20; k++) send(0, pk[k]);
                idle(0);
            end
            begin
                repeat (40) @(posedge clk);
                #2;
                chk("bp_accepted", 64'(accepted), 64'd17);
                chk("bp_ready_low", 64'(ready_in_bus[0]), 64'h0);
                ready_out_bus[1] = 1'b1;
            end
        join
        wait_drain("bp");

        // Dropped packet on port 0 does not block port 1
        sf = mk(2'b00, 13);
        exp_q.push_back(ex(3, sf));
        fork
            begin
                send(0, mk(2'b01, 20));
                send(0, mk(2'b10, 20));
                send(0, mk(2'b10, 20));
                send(0, mk(2'b11, 20));
                idle(0);
            end
            begin
                send(1, sf);
                idle(1);
            end
        join
        exp_drops++;
        wait_drain("drop_pass");
        chk("drop_count_pkt", 64'(drop_count), 64'(exp_drops));

        // Saturation
        for (int i = 0; i < 300; i++) begin
            d = $urandom_range(16, 31);
            if (i % 3 == 0) begin
                send(0, mk(2'b00, d));
            end else begin
                send(0, mk(2'b01, d));
                send(0, mk(2'b10, d));
                send(0, mk(2'b11, d));
            end
            exp_drops = (exp_drops < 255) ? exp_drops + 1 : 255;
            if (i == 99) begin
                idle(0);
                repeat (4) @(posedge clk);
                #1;
                chk("drop_count_mid", 64'(drop_count), 64'(exp_drops));
            end
        end
        idle(0);
        wait_drain("drop_sat");
        chk("drop_count_sat", 64'(drop_count), 64'd255);

        // Reset in the middle of a packet
        f = mk(2'b01, 3);
        exp_q.push_back(ex(1, f));
        send(0, f);
        send(0, mk(2'b10, 3));
        send(0, mk(2'b10, 3));
        idle(0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("midrst_valid_out", 64'(valid_out_bus), 64'h0);
        chk("midrst_ready_in", 64'(ready_in_bus), 64'h0);
        chk("midrst_drop_count", 64'(drop_count), 64'h0);
        rst = 1'b0;
        wait_drain("midrst");
        sf = mk(2'b00, 3);
        exp_q.push_back(ex(1, sf));
        send(2, sf);
        idle(2);
        wait_drain("post_rst");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
